// File: rtl/m_seq_ctrl.sv
// RV32M sequencing controller: one-pass multiply, 32-step restoring divide.
// Optional macro M_DIV_BYPASS_EN short-circuits divide by 0 and unsigned divide by 1.
`ifndef MUX_MULTA_LENGTH
`define MUX_MULTA_LENGTH 1
`endif
`ifndef MUX_MULTB_LENGTH
`define MUX_MULTB_LENGTH 1
`endif
`ifndef MUX_DIV_REM_LENGTH
`define MUX_DIV_REM_LENGTH 1
`endif
`ifndef MUX_MULTA_R_UNSIGNED
`define MUX_MULTA_R_UNSIGNED 0
`endif
`ifndef MUX_MULTA_R_SIGNED
`define MUX_MULTA_R_SIGNED 1
`endif
`ifndef MUX_MULTB_D_UNSIGNED
`define MUX_MULTB_D_UNSIGNED 0
`endif
`ifndef MUX_MULTB_D_SIGNED
`define MUX_MULTB_D_SIGNED 1
`endif
`ifndef MUX_DIV_REM_R
`define MUX_DIV_REM_R 0
`endif
`ifndef MUX_DIV_REM_Z
`define MUX_DIV_REM_Z 1
`endif

module m_seq_ctrl (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           start,
    input  logic [2:0]                     op,
    input  logic [31:0]                    rs1,
    input  logic [31:0]                    rs2,
    output logic                           busy,
    output logic                           done,
    output logic [31:0]                    result,
    output logic [`MUX_MULTA_LENGTH-1:0]   mux_multA,
    output logic [`MUX_MULTB_LENGTH-1:0]   mux_multB,
    output logic [`MUX_DIV_REM_LENGTH-1:0] mux_div_rem,
    output logic [31:0]                    R,
    output logic [62:0]                    D,
    output logic [31:0]                    Z,
    input  logic [31:0]                    sub_result,
    input  logic [31:0]                    div_rem,
    input  logic [31:0]                    div_rem_neg,
    input  logic [63:0]                    product
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    localparam logic [`MUX_MULTA_LENGTH-1:0] MA_U = `MUX_MULTA_LENGTH'(`MUX_MULTA_R_UNSIGNED);
    localparam logic [`MUX_MULTA_LENGTH-1:0] MA_S = `MUX_MULTA_LENGTH'(`MUX_MULTA_R_SIGNED);
    localparam logic [`MUX_MULTB_LENGTH-1:0] MB_U = `MUX_MULTB_LENGTH'(`MUX_MULTA_R_UNSIGNED);
    localparam logic [`MUX_MULTB_LENGTH-1:0] MB_S = `MUX_MULTB_LENGTH'(`MUX_MULTB_D_SIGNED);
    localparam logic [`MUX_DIV_REM_LENGTH-1:0] DR_R = `MUX_DIV_REM_LENGTH'(`MUX_DIV_REM_R);
    localparam logic [`MUX_DIV_REM_LENGTH-1:0] DR_Z = `MUX_DIV_REM_LENGTH'(`MUX_DIV_REM_Z);

    state_t                          state_q, state_d;
    logic [2:0]                      op_q, op_d;
    logic                            neg_a_q, neg_a_d;
    logic                            neg_b_q, neg_b_d;
    logic                            div_zero_q, div_zero_d;
    logic [4:0]                      cnt_q, cnt_d;
    logic                            done_q, done_d;
    logic [31:0]                     result_q, result_d;
    logic [31:0]                     r_q, r_d;
    logic [62:0]                     d_q, d_d;
    logic [31:0]                     z_q, z_d;
    logic [`MUX_MULTA_LENGTH-1:0]    mux_multa_q, mux_multa_d;
    logic [`MUX_MULTB_LENGTH-1:0]    mux_multb_q, mux_multb_d;
    logic [`MUX_DIV_REM_LENGTH-1:0]  mux_div_rem_q, mux_div_rem_d;

    logic        sgn;
    logic        neg;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        neg_a_d       = neg_a_q;
        neg_b_d       = neg_b_q;
        div_zero_d    = div_zero_q;
        cnt_d         = cnt_q;
        done_d        = 1'b0;
        result_d      = result_q;
        r_d           = r_q;
        d_d           = d_q;
        z_d           = z_q;
        mux_multa_d   = mux_multa_q;
        mux_multb_d   = mux_multb_q;
        mux_div_rem_d = mux_div_rem_q;
        // DIV and REM (op 4, 6) are the signed divides
        sgn   = ~op[0];
        abs_a = (sgn && rs1[31]) ? 32'(-rs1) : rs1;
        abs_b = (sgn && rs2[31]) ? 32'(-rs2) : rs2;
        neg   = op_q[1] ? neg_a_q : ((neg_a_q ^ neg_b_q) & ~div_zero_q);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d = op;
                    if (!op[2]) begin
                        r_d         = rs1;
                        d_d         = {rs2, 31'b0};
                        mux_multa_d = (op == 3'd1 || op == 3'd2) ? MA_S : MA_U;
                        mux_multb_d = (op == 3'd1) ? MB_S : MB_U;
                        state_d     = MUL;
                    end else begin
                        neg_a_d    = sgn & rs1[31];
                        neg_b_d    = sgn & rs2[31];
                        div_zero_d = (rs2 == 32'd0);
                        r_d        = abs_a;
                        d_d        = {abs_b, 31'b0};
                        z_d        = 32'd0;
                        cnt_d      = 5'd31;
                        state_d    = DIV;
`ifdef M_DIV_BYPASS_EN
                        if (rs2 == 32'd0) begin
                            z_d           = 32'hFFFF_FFFF;
                            mux_div_rem_d = op[1] ? DR_R : DR_Z;
                            state_d       = FIX;
                        end else if (rs2 == 32'd1 && op[0]) begin
                            z_d           = rs1;
                            r_d           = 32'd0;
                            mux_div_rem_d = op[1] ? DR_R : DR_Z;
                            state_d       = FIX;
                        end
`endif
                    end
                end
            end
            MUL: begin
                result_d = (op_q[1:0] == 2'd0) ? product[31:0] : product[63:32];
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            DIV: begin
                if (d_q[62:32] == 31'd0 && r_q >= d_q[31:0]) begin
                    r_d        = sub_result;
                    z_d[cnt_q] = 1'b1;
                end
                d_d   = d_q >> 1;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    mux_div_rem_d = op_q[1] ? DR_R : DR_Z;
                    state_d       = FIX;
                end
            end
            FIX: begin
                result_d = neg ? div_rem_neg : div_rem;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            op_q          <= 3'd0;
            neg_a_q       <= 1'b0;
            neg_b_q       <= 1'b0;
            div_zero_q    <= 1'b0;
            cnt_q         <= 5'd0;
            done_q        <= 1'b0;
            result_q      <= 32'd0;
            r_q           <= 32'd0;
            d_q           <= 63'd0;
            z_q           <= 32'd0;
            mux_multa_q   <= MA_U;
            mux_multb_q   <= MB_U;
            mux_div_rem_q <= DR_R;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            neg_a_q       <= neg_a_d;
            neg_b_q       <= neg_b_d;
            div_zero_q    <= div_zero_d;
            cnt_q         <= cnt_d;
            done_q        <= done_d;
            result_q      <= result_d;
            r_q           <= r_d;
            d_q           <= d_d;
            z_q           <= z_d;
            mux_multa_q   <= mux_multa_d;
            mux_multb_q   <= mux_multb_d;
            mux_div_rem_q <= mux_div_rem_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign result      = result_q;
    assign R           = r_q;
    assign D           = d_q;
    assign Z           = z_q;
    assign mux_multA   = mux_multa_q;
    assign mux_multB   = mux_multb_q;
    assign mux_div_rem = mux_div_rem_q;

endmodule

// File: tb/tb_m_seq_ctrl.sv
// Scoreboard bench for m_seq_ctrl with a behavioural m_alu and an
// arithmetic reference model of the RV32M results and latencies.
`ifndef MUX_MULTA_LENGTH
`define MUX_MULTA_LENGTH 1
`endif
`ifndef MUX_MULTB_LENGTH
`define MUX_MULTB_LENGTH 1
`endif
`ifndef MUX_DIV_REM_LENGTH
`define MUX_DIV_REM_LENGTH 1
`endif
`ifndef MUX_MULTA_R_UNSIGNED
`define MUX_MULTA_R_UNSIGNED 0
`endif
`ifndef MUX_MULTA_R_SIGNED
`define MUX_MULTA_R_SIGNED 1
`endif
`ifndef MUX_MULTB_D_UNSIGNED
`define MUX_MULTB_D_UNSIGNED 0
`endif
`ifndef MUX_MULTB_D_SIGNED
`define MUX_MULTB_D_SIGNED 1
`endif
`ifndef MUX_DIV_REM_R
`define MUX_DIV_REM_R 0
`endif
`ifndef MUX_DIV_REM_Z
`define MUX_DIV_REM_Z 1
`endif

module tb_m_seq_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [`MUX_MULTA_LENGTH-1:0]   mux_multA;
    logic [`MUX_MULTB_LENGTH-1:0]   mux_multB;
    logic [`MUX_DIV_REM_LENGTH-1:0] mux_div_rem;
    logic [31:0] R;
    logic [62:0] D;
    logic [31:0] Z;
    logic [31:0] sub_result;
    logic [31:0] div_rem;
    logic [31:0] div_rem_neg;
    logic [63:0] product;

    m_seq_ctrl dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op),
        .rs1(rs1), .rs2(rs2), .busy(busy), .done(done),
        .result(result), .mux_multA(mux_multA),
        .mux_multB(mux_multB), .mux_div_rem(mux_div_rem),
        .R(R), .D(D), .Z(Z), .sub_result(sub_result),
        .div_rem(div_rem), .div_rem_neg(div_rem_neg),
        .product(product)
    );

    always #5 clk = ~clk;

    // behavioural m_alu
    logic signed [32:0] a_ext, b_ext;
    logic signed [65:0] p_full;
    assign a_ext = {(mux_multA == `MUX_MULTA_LENGTH'(`MUX_MULTA_R_SIGNED)) & R[31], R};
    assign b_ext = {(mux_multB == `MUX_MULTB_LENGTH'(`MUX_MULTB_D_SIGNED)) & D[62], D[62:31]};
    assign p_full = a_ext * b_ext;
    assign product = p_full[63:0];
    assign sub_result = R - D[31:0];
    assign div_rem = (mux_div_rem == `MUX_DIV_REM_LENGTH'(`MUX_DIV_REM_Z)) ? Z : R;
    assign div_rem_neg = -div_rem;

    typedef struct {
        logic [31:0] res;
        int          due;
        logic [2:0]  op;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        r = 32'd0;
        case (o)
            3'd0: begin p = 64'(sa * sb); r = p[31:0];  end
            3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
            3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
            3'd4: begin p = 64'(sa / sb); r = (b == 0) ? 32'hFFFF_FFFF : p[31:0]; end
            3'd5: begin p = 64'(ua / ub); r = (b == 0) ? 32'hFFFF_FFFF : p[31:0]; end
            3'd6: begin p = 64'(sa % sb); r = (b == 0) ? a : p[31:0]; end
            default: begin p = 64'(ua % ub); r = (b == 0) ? a : p[31:0]; end
        endcase
        return r;
    endfunction

    function automatic int latency(input logic [2:0] o, input logic [31:0] b);
        if (!o[2]) return 2;
`ifdef M_DIV_BYPASS_EN
        if (b == 32'd0 || (b == 32'd1 && o[0])) return 2;
`endif
        if (b == 32'hDEAD_BEEF) return 34;
        return 34;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // monitor: pops expected response whenever the DUT presents done
    always @(negedge clk) begin
        if (resetn && done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 64'(result), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                check($sformatf("result_op%0d", e.op), 64'(result), 64'(e.res));
                check($sformatf("latency_op%0d", e.op), 64'(cyc), 64'(e.due));
                check("busy_low_at_done", 64'(busy), 64'd0);
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int w;
        w = 0;
        while (busy && w < 200) begin
            if ($urandom_range(2) == 0) begin
                start = 1'b1;
                op    = 3'($urandom);
                rs1   = $urandom;
                rs2   = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            w++;
        end
        if (busy) begin
            $display("FAIL busy_timeout: got busy=1 required busy=0");
            $fatal(1);
        end
        start = 1'b1;
        op    = o;
        rs1   = a;
        rs2   = b;
        q.push_back('{ref_model(o, a, b), cyc + latency(o, b), o});
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_R", 64'(R), 64'd0);
        check("rst_D", 64'(D), 64'd0);
        check("rst_Z", 64'(Z), 64'd0);
        check("rst_multA", 64'(mux_multA), 64'(`MUX_MULTA_R_UNSIGNED));
        check("rst_multB", 64'(mux_multB), 64'(`MUX_MULTA_R_UNSIGNED));
        check("rst_div_rem", 64'(mux_div_rem), 64'(`MUX_DIV_REM_R));
        resetn = 1'b1;
        @(negedge clk);

        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd2, 32'hFFFF_FFFF, 32'd2);
        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2);
        issue(3'd5, 32'd100, 32'd7);
        issue(3'd7, 32'd100, 32'd7);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'd5, 32'd5, 32'd0);
        issue(3'd6, 32'hFFFF_FFFB, 32'd0);
        issue(3'd5, 32'h1234_5678, 32'd1);
        issue(3'd7, 32'h1234_5678, 32'd1);
        issue(3'd0, 32'd7, 32'd9);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000);

        // abort a divide mid-loop
        issue(3'd4, 32'h7FFF_FFFF, 32'd3);
        repeat (9) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_idle", 64'(busy), 64'd0);

        for (int i = 0; i < 200; i++) begin
            issue(3'($urandom), pick(), pick());
        end

        for (int w = 0; w < 100 && q.size() != 0; w++) @(negedge clk);
        check("drain_queue", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
